seq_shifter: RTL
================

Name: seq_shifter

Overview:
- Parametrised multi-cycle shifter. Shifts an N-bit operand by a runtime amount in one of four modes: logical left, logical right, arithmetic right, rotate left.
- Moves at most STEP bit positions per clock and uses a start/busy/done handshake.
- Sits beside the ALU for shift instructions, replacing the fixed shift-left-by-2 wiring with a general, reusable unit. The branch-offset case is SLL by 2.

Parameters:
- N, 32, operand and result width in bits; must be ≥2.
- STEP, 1, maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ N.
- SW (localparam), $clog2(N), width of the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROTL.
- a  input  N  operand; sampled on acceptance.
- shamt  input  SW  shift amount, 0..N-1; sampled on acceptance.
- result  output  N  shifted value; valid when done=1, then held.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result becomes valid.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous, active-high and overrides everything.
- Reset values: state IDLE, result 0, busy 0, done 0, internal remaining-count 0.
- States:
  - IDLE: busy=0, done=0.
  - BUSY: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE, start=1: at the edge, capture a into the work register, and capture op and shamt into remaining-count. Go to BUSY.
- IDLE, start=0: stay in IDLE.
- BUSY, remaining>0: each edge shifts the work register by s = min(STEP, remaining) in the captured mode, then remaining -= s. Stay in BUSY.
- BUSY, remaining=0: at the edge, copy the work register to result and go to DONE.
- DONE, start=1: treat exactly as IDLE with start=1 (back-to-back). done still pulses for only that one cycle.
- DONE, start=0: go to IDLE.
- start is ignored while in BUSY. op, a and shamt may change freely after acceptance without effect.
- Latency: a start accepted at the end of cycle t gives done=1 in cycle t+2+ceil(shamt/STEP).
  - shamt=0: done in cycle t+2 with result=a.
  - Throughput: one operation per 2+ceil(shamt/STEP) cycles.
- Mode arithmetic, per step of s bits:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the captured sign bit a[N-1], which is preserved across all steps.
  - ROTL: bits leaving the MSB re-enter at the LSB.
- The final partial step (remaining < STEP) shifts by exactly remaining bits. It never overshoots.
- result holds its value through IDLE, BUSY and DONE. It changes only on the BUSY→DONE transition or on rst.
- Reset mid-operation: the next edge with rst=1 aborts the operation and restores all reset values. No done pulse follows.

Test Plan:
- N=32, STEP=1, op=SLL, a=0x00000001, shamt=2 → busy high 3 cycles; done in cycle t+4; result=0x00000004.
- op=SRA, a=0x80000000, shamt=4 → result=0xF8000000. Repeat with op=SRL → result=0x08000000.
- op=ROTL, a=0x80000001, shamt=1 → result=0x00000003. shamt=0 with a=0xDEADBEEF, any op → done in cycle t+2, result=0xDEADBEEF.
- Handshake: pulse start again while busy with a different a → ignored; original result delivered. start held high in the DONE cycle → second operation accepted back-to-back, two separate done pulses.
- STEP=4, op=SRL, a=0xFFFFFFFF, shamt=31 → 8 shift cycles (7×4, then 3); done in cycle t+10; result=0x00000001.
- Assert rst for one cycle mid-BUSY → next cycle busy=0, done=0, result=0. No done pulse until a new start.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTL by a runtime amount, at most STEP bits per clock,
// with a start/busy/done handshake and a held result register.
module seq_shifter #(
  parameter int unsigned N    = 32,
  parameter int unsigned STEP = 1,
  localparam int unsigned SW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic [N-1:0]  result,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpSll  = 2'b00,
    OpSrl  = 2'b01,
    OpSra  = 2'b10,
    OpRotl = 2'b11
  } op_e;

  // One extra bit so STEP and N stay representable when they equal 2**SW.
  localparam logic [SW:0] StepW = STEP[SW:0];
  localparam logic [SW:0] NW    = N[SW:0];

  state_e        state_q;
  op_e           op_q;
  logic [N-1:0]  work_q;
  logic [SW-1:0] rem_q;

  logic [SW:0]   rem_ext;
  logic [SW:0]   step_amt;
  logic [N-1:0]  shifted;

  // Final partial step shifts by exactly the remaining count, never past it.
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    step_amt = (rem_ext < StepW) ? rem_ext : StepW;
  end

  always_comb begin
    shifted = work_q;
    unique case (op_q)
      OpSll:   shifted = work_q << step_amt;
      OpSrl:   shifted = work_q >> step_amt;
      OpSra:   shifted = $unsigned($signed(work_q) >>> step_amt);
      OpRotl:  shifted = (work_q << step_amt) | (work_q >> (NW - step_amt));
      default: shifted = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpSll;
      work_q  <= '0;
      rem_q   <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            work_q  <= a;
            op_q    <= op_e'(op);
            rem_q   <= shamt;
            busy    <= 1'b1;
            state_q <= StBusy;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          if (rem_q != '0) begin
            work_q <= shifted;
            rem_q  <= rem_q - step_amt[SW-1:0];
          end else begin
            result  <= work_q;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
